multicycle_control: RTL and testbench

Control unit for the multicycle RV32I datapath: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It drives the 3-bit ALUControl that the datapath ALU consumes, and every datapath mux select and write enable. It sits between the instruction register and zero flag (inputs) and the shared-memory datapath (outputs).

---
 rtl/multicycle_control.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Latency: outputs combinational from state (PCWrite also uses zero; ALUControl/ImmSrc use op/funct).
// No backpressure: one state transition per clock, reset aborts any instruction in flight.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t     state_q, state_d;
  state_t     out_state;
  logic [1:0] alu_op;
  logic       branch;
  logic       pc_update;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;

  // State register with synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; unused encodings and illegal opcodes fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
        else if (op == OP_R)            state_d = S_EXECR;
        else if (op == OP_IALU)         state_d = S_EXECI;
        else if (op == OP_JAL)          state_d = S_JAL;
        else if (op == OP_BEQ)          state_d = S_BEQ;
        else                            state_d = S_FETCH;
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // While reset is high the muxes present FETCH values so the datapath sees a clean start
  assign out_state = reset ? S_FETCH : state_q;

  // Moore output decode from (effective) state
  always_comb begin
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = 2'b00;
    branch        = 1'b0;
    pc_update     = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    unique case (out_state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        pc_update    = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by reset so an aborted instruction never writes state
  assign PCWrite  = ~reset & (pc_update | (branch & zero));
  assign MemWrite = ~reset & mem_write_raw;
  assign IRWrite  = ~reset & ir_write_raw;
  assign RegWrite = ~reset & reg_write_raw;
  assign state    = state_q;

  // ALU decoder: subtract only for R-type with funct7[5] set (addi never subtracts)
  always_comb begin
    ALUControl = 3'b000;
    unique case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        unique case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    ImmSrc = 2'b00;
    if (op == OP_SW)       ImmSrc = 2'b01;
    else if (op == OP_BEQ) ImmSrc = 2'b10;
    else if (op == OP_JAL) ImmSrc = 2'b11;
    else                   ImmSrc = 2'b00;
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .ALUControl(ALUControl), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       pcw, irw, memw, regw, adr;
    logic [1:0] res, srca, srcb, imm;
    logic [2:0] aluc;
  } exp_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         n;
    logic [5:0][3:0] seq;   // seq[0] is the FETCH cycle
    logic [2:0] aluc;       // ALUControl expected in S6/S8
    logic [1:0] imm;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [6:0] o, input logic [2:0] f3,
                              input logic f7, input logic z, input int n,
                              input logic [23:0] s, input logic [2:0] a, input logic [1:0] im);
    vec_t v;
    v.name = nm; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.n = n;
    v.seq = s; v.aluc = a; v.imm = im;
    return v;
  endfunction

  // Expected outputs for one cycle, written straight from the state table
  function automatic exp_t st_exp(input logic [3:0] st, input logic z,
                                  input logic [2:0] ex_aluc, input logic [1:0] im);
    exp_t e;
    e.st = st; e.pcw = 0; e.irw = 0; e.memw = 0; e.regw = 0; e.adr = 0;
    e.res = 2'b00; e.srca = 2'b00; e.srcb = 2'b00; e.imm = im; e.aluc = 3'b000;
    case (st)
      4'd0:  begin e.irw = 1; e.pcw = 1; e.srcb = 2'b10; e.res = 2'b10; end
      4'd1:  begin e.srca = 2'b01; e.srcb = 2'b01; end
      4'd2:  begin e.srca = 2'b10; e.srcb = 2'b01; end
      4'd3:  begin e.adr = 1; end
      4'd4:  begin e.res = 2'b01; e.regw = 1; end
      4'd5:  begin e.adr = 1; e.memw = 1; end
      4'd6:  begin e.srca = 2'b10; e.aluc = ex_aluc; end
      4'd7:  begin e.regw = 1; end
      4'd8:  begin e.srca = 2'b10; e.srcb = 2'b01; e.aluc = ex_aluc; end
      4'd9:  begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1; end
      4'd10: begin e.srca = 2'b10; e.aluc = 3'b001; e.pcw = z; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic compare_rec(input string tag, input exp_t e);
    chk({tag, ".state"},      state,      e.st);
    chk({tag, ".PCWrite"},    PCWrite,    e.pcw);
    chk({tag, ".IRWrite"},    IRWrite,    e.irw);
    chk({tag, ".MemWrite"},   MemWrite,   e.memw);
    chk({tag, ".RegWrite"},   RegWrite,   e.regw);
    chk({tag, ".AdrSrc"},     AdrSrc,     e.adr);
    chk({tag, ".ResultSrc"},  ResultSrc,  e.res);
    chk({tag, ".ALUSrcA"},    ALUSrcA,    e.srca);
    chk({tag, ".ALUSrcB"},    ALUSrcB,    e.srcb);
    chk({tag, ".ImmSrc"},     ImmSrc,     e.imm);
    chk({tag, ".ALUControl"}, ALUControl, e.aluc);
  endtask

  // Called at a negedge while the DUT is in FETCH; returns at the next FETCH negedge
  task automatic run_vec(input vec_t v);
    exp_t e;
    op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
    for (int k = 0; k < v.n; k++)
      sb_q.push_back(st_exp(v.seq[k], v.z, v.aluc, v.imm));
    for (int k = 0; k < v.n; k++) begin
      #1;
      e = sb_q.pop_front();
      compare_rec($sformatf("%s.c%0d", v.name, k), e);
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0]  = mk("lw",     7'b0000011, 3'b010, 1'b0, 1'b0, 5, {4'd0,4'd4,4'd3,4'd2,4'd1,4'd0}, 3'b000, 2'b00);
    vecs[1]  = mk("sw",     7'b0100011, 3'b010, 1'b0, 1'b0, 4, {4'd0,4'd0,4'd5,4'd2,4'd1,4'd0}, 3'b000, 2'b01);
    vecs[2]  = mk("sub",    7'b0110011, 3'b000, 1'b1, 1'b0, 4, {4'd0,4'd0,4'd7,4'd6,4'd1,4'd0}, 3'b001, 2'b00);
    vecs[3]  = mk("add",    7'b0110011, 3'b000, 1'b0, 1'b0, 4, {4'd0,4'd0,4'd7,4'd6,4'd1,4'd0}, 3'b000, 2'b00);
    vecs[4]  = mk("slt",    7'b0110011, 3'b010, 1'b0, 1'b0, 4, {4'd0,4'd0,4'd7,4'd6,4'd1,4'd0}, 3'b101, 2'b00);
    vecs[5]  = mk("or",     7'b0110011, 3'b110, 1'b0, 1'b0, 4, {4'd0,4'd0,4'd7,4'd6,4'd1,4'd0}, 3'b011, 2'b00);
    vecs[6]  = mk("and",    7'b0110011, 3'b111, 1'b0, 1'b0, 4, {4'd0,4'd0,4'd7,4'd6,4'd1,4'd0}, 3'b010, 2'b00);
    vecs[7]  = mk("sll",    7'b0110011, 3'b001, 1'b0, 1'b0, 4, {4'd0,4'd0,4'd7,4'd6,4'd1,4'd0}, 3'b000, 2'b00);
    vecs[8]  = mk("addi7",  7'b0010011, 3'b000, 1'b1, 1'b0, 4, {4'd0,4'd0,4'd7,4'd8,4'd1,4'd0}, 3'b000, 2'b00);
    vecs[9]  = mk("ori",    7'b0010011, 3'b110, 1'b0, 1'b0, 4, {4'd0,4'd0,4'd7,4'd8,4'd1,4'd0}, 3'b011, 2'b00);
    vecs[10] = mk("jal",    7'b1101111, 3'b000, 1'b0, 1'b0, 4, {4'd0,4'd0,4'd7,4'd9,4'd1,4'd0}, 3'b000, 2'b11);
    vecs[11] = mk("beq_z1", 7'b1100011, 3'b000, 1'b0, 1'b1, 3, {4'd0,4'd0,4'd0,4'd10,4'd1,4'd0}, 3'b000, 2'b10);
    vecs[12] = mk("beq_z0", 7'b1100011, 3'b000, 1'b0, 1'b0, 3, {4'd0,4'd0,4'd0,4'd10,4'd1,4'd0}, 3'b000, 2'b10);
    vecs[13] = mk("illegal",7'b1111111, 3'b000, 1'b0, 1'b0, 2, {4'd0,4'd0,4'd0,4'd0,4'd1,4'd0}, 3'b000, 2'b00);

    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;

    // Reset held for two cycles
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk("rst.state",    state,    4'd0);
      chk("rst.PCWrite",  PCWrite,  1'b0);
      chk("rst.IRWrite",  IRWrite,  1'b0);
      chk("rst.MemWrite", MemWrite, 1'b0);
      chk("rst.RegWrite", RegWrite, 1'b0);
      chk("rst.ALUSrcB",  ALUSrcB,  2'b10);
    end
    @(negedge clk);
    reset = 1'b0;

    // Table-driven instruction vectors, back to back
    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // sw aborted by reset in S5
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("swab.state_s5",  state,    4'd5);
    chk("swab.mw_pre",    MemWrite, 1'b1);
    reset = 1'b1; #1;
    chk("swab.mw_rst",    MemWrite, 1'b0);
    chk("swab.adr_rst",   AdrSrc,   1'b0);
    chk("swab.rw_rst",    RegWrite, 1'b0);
    @(negedge clk);
    reset = 1'b0; #1;
    chk("swab.state_s0",  state,    4'd0);
    chk("swab.irw_s0",    IRWrite,  1'b1);

    // beq: zero sampled combinationally within S10, reset overrides
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("beqz.state",     state,    4'd10);
    chk("beqz.pcw_z0",    PCWrite,  1'b0);
    zero = 1'b1; #1;
    chk("beqz.pcw_z1",    PCWrite,  1'b1);
    reset = 1'b1; #1;
    chk("beqz.pcw_rst",   PCWrite,  1'b0);
    @(negedge clk);
    reset = 1'b0; zero = 1'b0; #1;
    chk("beqz.state_s0",  state,    4'd0);

    chk("sb.empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
